// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and edge-detects active-low buttons,
// with optional per-channel auto-repeat while a button stays held.
module button_conditioner #(
    parameter int N_BUTTONS       = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] btn_n,
    input  logic                 repeat_en,
    output logic [N_BUTTONS-1:0] pressed,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic [N_BUTTONS-1:0] release_pulse,
    output logic [N_BUTTONS-1:0] repeat_pulse,
    output logic                 any_press
);
    localparam int MAX_A = DEBOUNCE_CYCLES > REPEAT_DELAY ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_P = MAX_A > REPEAT_PERIOD ? MAX_A : REPEAT_PERIOD;
    localparam int W = $clog2(MAX_P + 1);
    localparam logic [W-1:0] DB_LAST = W'(DEBOUNCE_CYCLES - 1);
    localparam logic [W-1:0] RD_LAST = W'(REPEAT_DELAY - 1);
    localparam logic [W-1:0] RP_LAST = W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, WAIT_FIRST, REPEATING} rpt_state_t;

    logic [N_BUTTONS-1:0] s1, s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= btn_n;
            s2 <= s1;
        end
    end

    assign any_press = |press_pulse;

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
        logic [W-1:0] db_cnt, hold_cnt, hold_cnt_n;
        logic         raw, flip, rise, fall, p, pp, rp, rep, rep_n;
        rpt_state_t   state, state_n;

        assign raw  = ~s2[g];
        assign flip = (raw != p) && (db_cnt == DB_LAST);
        assign rise = flip && raw;
        assign fall = flip && !raw;

        assign pressed[g]       = p;
        assign press_pulse[g]   = pp;
        assign release_pulse[g] = rp;
        assign repeat_pulse[g]  = rep;

        always_ff @(posedge clk) begin
            if (rst) begin
                db_cnt   <= '0;
                p        <= 1'b0;
                pp       <= 1'b0;
                rp       <= 1'b0;
                rep      <= 1'b0;
                state    <= IDLE;
                hold_cnt <= '0;
            end else begin
                db_cnt   <= (raw == p || flip) ? '0 : (&db_cnt ? db_cnt : db_cnt + 1'b1);
                p        <= p ^ flip;
                pp       <= rise;
                rp       <= fall;
                rep      <= rep_n;
                state    <= state_n;
                hold_cnt <= hold_cnt_n;
            end
        end

        always_comb begin
            state_n    = state;
            hold_cnt_n = &hold_cnt ? hold_cnt : hold_cnt + 1'b1;
            rep_n      = 1'b0;
            case (state)
                IDLE: begin
                    hold_cnt_n = '0;
                    state_n    = rise ? WAIT_FIRST : IDLE;
                end
                WAIT_FIRST: if (hold_cnt == RD_LAST) begin
                    rep_n      = 1'b1;
                    state_n    = REPEATING;
                    hold_cnt_n = '0;
                end
                REPEATING: if (hold_cnt == RP_LAST) begin
                    rep_n      = 1'b1;
                    hold_cnt_n = '0;
                end
                default: state_n = IDLE;
            endcase
            // a release being accepted this edge must already silence repeats
            if (!repeat_en || fall || (!p && !rise)) begin
                state_n    = IDLE;
                hold_cnt_n = '0;
                rep_n      = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of debounce, pulses, auto-repeat and reset.
module tb_button_conditioner;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn_n = 3'b111;
    logic       repeat_en = 1'b0;
    logic [2:0] pressed, press_pulse, release_pulse, repeat_pulse;
    logic       any_press;

    int checks = 0;
    int passes = 0;
    int press_cnt [3] = '{0, 0, 0};
    int rel_cnt   [3] = '{0, 0, 0};
    int rep_cnt   [3] = '{0, 0, 0};
    int overlap = 0;

    button_conditioner #(
        .N_BUTTONS(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk), .rst(rst), .btn_n(btn_n), .repeat_en(repeat_en),
        .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .repeat_pulse(repeat_pulse), .any_press(any_press)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            press_cnt[i] += int'(press_pulse[i]);
            rel_cnt[i]   += int'(release_pulse[i]);
            rep_cnt[i]   += int'(repeat_pulse[i]);
            overlap      += int'(press_pulse[i] & release_pulse[i]);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // reset
        step(3);
        check("rst_pressed", 32'(pressed), 0);
        check("rst_press", 32'(press_pulse), 0);
        check("rst_release", 32'(release_pulse), 0);
        check("rst_repeat", 32'(repeat_pulse), 0);
        check("rst_any", 32'(any_press), 0);
        rst = 1'b0;
        step(2);
        // clean press on channel 0, repeat disabled
        btn_n = 3'b110;
        step(5);
        check("clean_pre", 32'(pressed), 0);
        step(1);
        check("clean_pressed", 32'(pressed), 3'b001);
        check("clean_pulse", 32'(press_pulse), 3'b001);
        check("clean_any", 32'(any_press), 1);
        step(1);
        check("clean_pulse_end", 32'(press_pulse), 0);
        check("clean_any_end", 32'(any_press), 0);
        check("clean_hold", 32'(pressed), 3'b001);
        step(10);
        // release with one 2-cycle bounce
        btn_n[0] = 1'b1;
        step(2);
        btn_n[0] = 1'b0;
        step(2);
        btn_n[0] = 1'b1;
        step(5);
        check("rel_pre", 32'(pressed), 3'b001);
        check("rel_pre_pulse", 32'(release_pulse), 0);
        step(1);
        check("rel_pressed", 32'(pressed), 0);
        check("rel_pulse", 32'(release_pulse), 3'b001);
        step(1);
        check("rel_pulse_end", 32'(release_pulse), 0);
        check("rel_count0", 32'(rel_cnt[0]), 1);
        check("norep_ch0", 32'(rep_cnt[0]), 0);
        // bounce rejection on channel 1
        for (int i = 0; i < 10; i++) begin
            btn_n[1] = i[0];
            step(2);
        end
        btn_n[1] = 1'b1;
        step(8);
        check("bounce_pressed", 32'(pressed), 0);
        check("bounce_press_cnt", 32'(press_cnt[1]), 0);
        check("bounce_rel_cnt", 32'(rel_cnt[1]), 0);
        // auto-repeat on channel 2
        repeat_en = 1'b1;
        btn_n = 3'b011;
        step(6);
        check("rpt_press", 32'(press_pulse), 3'b100);
        step(9);
        check("rpt_before_first", 32'(repeat_pulse), 0);
        step(1);
        check("rpt_first", 32'(repeat_pulse), 3'b100);
        step(1);
        check("rpt_first_end", 32'(repeat_pulse), 0);
        step(2);
        check("rpt_13", 32'(repeat_pulse), 3'b100);
        step(3);
        check("rpt_16", 32'(repeat_pulse), 3'b100);
        step(3);
        check("rpt_19", 32'(repeat_pulse), 3'b100);
        btn_n = 3'b111;
        step(3);
        check("rpt_22", 32'(repeat_pulse), 3'b100);
        step(3);
        check("rpt_rel_pulse", 32'(release_pulse), 3'b100);
        check("rpt_rel_norep", 32'(repeat_pulse), 0);
        step(10);
        check("rpt_total", 32'(rep_cnt[2]), 5);
        check("rpt_rel_once", 32'(rel_cnt[2]), 1);
        // held with repeat disabled, then enabled mid-hold
        repeat_en = 1'b0;
        btn_n = 3'b011;
        step(6);
        check("norpt_press", 32'(press_pulse), 3'b100);
        step(15);
        repeat_en = 1'b1;
        step(15);
        check("norpt_total", 32'(rep_cnt[2]), 5);
        btn_n = 3'b111;
        step(8);
        repeat_en = 1'b0;
        // simultaneous press
        btn_n = 3'b000;
        step(5);
        check("sim_pre", 32'(press_pulse), 0);
        step(1);
        check("sim_pulse", 32'(press_pulse), 3'b111);
        check("sim_any", 32'(any_press), 1);
        step(1);
        check("sim_any_end", 32'(any_press), 0);
        btn_n = 3'b111;
        step(5);
        step(1);
        check("sim_release", 32'(release_pulse), 3'b111);
        step(4);
        // reset in the middle of a debounce count
        btn_n = 3'b110;
        step(2);
        rst = 1'b1;
        step(3);
        check("midrst_pressed", 32'(pressed), 0);
        check("midrst_press", 32'(press_pulse), 0);
        rst = 1'b0;
        step(5);
        check("midrst_pre", 32'(press_pulse), 0);
        step(1);
        check("midrst_pulse", 32'(press_pulse), 3'b001);
        step(1);
        check("midrst_pulse_end", 32'(press_pulse), 0);
        btn_n = 3'b111;
        step(10);
        check("tot_press0", 32'(press_cnt[0]), 3);
        check("tot_press1", 32'(press_cnt[1]), 1);
        check("tot_press2", 32'(press_cnt[2]), 3);
        check("tot_rel0", 32'(rel_cnt[0]), 3);
        check("tot_rel2", 32'(rel_cnt[2]), 3);
        check("no_overlap", 32'(overlap), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
